// File: rtl/bram_pkg.sv
// Shared lane geometry and pack/unpack helpers for the snapshot RAM.
package bram_pkg;

  localparam int unsigned LANE_W    = 12;
  localparam int unsigned NUM_LANES = 12;
  localparam int unsigned WORD_W    = LANE_W * NUM_LANES;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t             lanes_t [NUM_LANES];
  typedef logic [WORD_W-1:0] word_t;

  // Lane k lands in bits [12k+11:12k]; lane 0 is the least significant.
  function automatic word_t pack_lanes(input lanes_t lanes);
    word_t w;
    w = '0;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      w[k*LANE_W +: LANE_W] = lanes[k];
    end
    return w;
  endfunction

  // Inverse of pack_lanes.
  function automatic lanes_t unpack_lanes(input word_t w);
    lanes_t lanes;
    for (int k = 0; k < int'(NUM_LANES); k++) begin
      lanes[k] = w[k*LANE_W +: LANE_W];
    end
    return lanes;
  endfunction

endpackage

// File: rtl/bram.sv
// Single-port snapshot RAM: 12 lanes x 12 bits per word, read-first,
// registered read data with an asynchronously cleared output register.
module bram
  import bram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH       = 144,
  parameter int unsigned RAM_ADDR_BITS   = 9,
  parameter int unsigned INIT_START_ADDR = 0,
  parameter int unsigned INIT_END_ADDR   = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ram_enable,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] address,
  input  logic [LANE_W-1:0]        input_data,
  input  logic [LANE_W-1:0]        input_data1,
  input  logic [LANE_W-1:0]        input_data2,
  input  logic [LANE_W-1:0]        input_data3,
  input  logic [LANE_W-1:0]        input_data4,
  input  logic [LANE_W-1:0]        input_data5,
  input  logic [LANE_W-1:0]        input_data6,
  input  logic [LANE_W-1:0]        input_data7,
  input  logic [LANE_W-1:0]        input_data8,
  input  logic [LANE_W-1:0]        input_data9,
  input  logic [LANE_W-1:0]        input_data10,
  input  logic [LANE_W-1:0]        input_data11,
  output logic [LANE_W-1:0]        output_data,
  output logic [LANE_W-1:0]        output_data1,
  output logic [LANE_W-1:0]        output_data2,
  output logic [LANE_W-1:0]        output_data3,
  output logic [LANE_W-1:0]        output_data4,
  output logic [LANE_W-1:0]        output_data5,
  output logic [LANE_W-1:0]        output_data6,
  output logic [LANE_W-1:0]        output_data7,
  output logic [LANE_W-1:0]        output_data8,
  output logic [LANE_W-1:0]        output_data9,
  output logic [LANE_W-1:0]        output_data10,
  output logic [LANE_W-1:0]        output_data11
);

  localparam int unsigned DEPTH = 1 << RAM_ADDR_BITS;

  // Elaboration-time sanity of the geometry and the zeroed window.
  if (RAM_WIDTH != WORD_W) begin : g_bad_width
    $error("bram: RAM_WIDTH must equal LANE_W*NUM_LANES");
  end
  if ((INIT_START_ADDR > INIT_END_ADDR) || (INIT_END_ADDR >= DEPTH)) begin : g_bad_init
    $error("bram: INIT_START_ADDR..INIT_END_ADDR must be an ordered range inside the array");
  end

  // Power-up image is all zeros: covers the INIT window and every other word,
  // so no read ever returns X. The array has no reset so it still maps to BRAM.
  logic [RAM_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [RAM_WIDTH-1:0] r_dout;

  lanes_t               w_in_lanes;
  lanes_t               w_out_lanes;
  logic [RAM_WIDTH-1:0] w_wr_word;
  logic                 w_we;
  logic                 w_re;

  assign w_in_lanes = '{input_data,  input_data1, input_data2,  input_data3,
                        input_data4, input_data5, input_data6,  input_data7,
                        input_data8, input_data9, input_data10, input_data11};
  assign w_wr_word  = RAM_WIDTH'(pack_lanes(w_in_lanes));

  // An X strobe compares unequal to 1, so it acts as inactive.
  assign w_we = (write_enable == 1'b1);
  assign w_re = (ram_enable == 1'b1);

  // Write port: independent of the read enable.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[address] <= w_wr_word;
    end
  end

  // Read port: read-first, so a same-cycle write still returns the old word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_re) begin
      r_dout <= r_mem[address];
    end
  end

  assign w_out_lanes = unpack_lanes(WORD_W'(r_dout));

  assign output_data   = w_out_lanes[0];
  assign output_data1  = w_out_lanes[1];
  assign output_data2  = w_out_lanes[2];
  assign output_data3  = w_out_lanes[3];
  assign output_data4  = w_out_lanes[4];
  assign output_data5  = w_out_lanes[5];
  assign output_data6  = w_out_lanes[6];
  assign output_data7  = w_out_lanes[7];
  assign output_data8  = w_out_lanes[8];
  assign output_data9  = w_out_lanes[9];
  assign output_data10 = w_out_lanes[10];
  assign output_data11 = w_out_lanes[11];

endmodule

// File: tb/tb_bram.sv
// Directed bench for bram with a reference memory and an expected-output queue.
module tb_bram;

  logic        clock = 1'b0;
  logic        reset;
  logic        ram_enable;
  logic        write_enable;
  logic [8:0]  address;
  logic [11:0] tb_in  [12];
  logic [11:0] tb_out [12];

  int n_chk  = 0;
  int n_pass = 0;

  logic [143:0] m_mem [512];
  logic [143:0] m_out;
  logic [143:0] exp_q [$];

  always #5 clock = ~clock;

  bram dut (
    .clock(clock), .reset(reset), .ram_enable(ram_enable),
    .write_enable(write_enable), .address(address),
    .input_data(tb_in[0]),    .input_data1(tb_in[1]),   .input_data2(tb_in[2]),
    .input_data3(tb_in[3]),   .input_data4(tb_in[4]),   .input_data5(tb_in[5]),
    .input_data6(tb_in[6]),   .input_data7(tb_in[7]),   .input_data8(tb_in[8]),
    .input_data9(tb_in[9]),   .input_data10(tb_in[10]), .input_data11(tb_in[11]),
    .output_data(tb_out[0]),  .output_data1(tb_out[1]), .output_data2(tb_out[2]),
    .output_data3(tb_out[3]), .output_data4(tb_out[4]), .output_data5(tb_out[5]),
    .output_data6(tb_out[6]), .output_data7(tb_out[7]), .output_data8(tb_out[8]),
    .output_data9(tb_out[9]), .output_data10(tb_out[10]), .output_data11(tb_out[11])
  );

  function automatic logic [143:0] obs_word();
    logic [143:0] w;
    for (int k = 0; k < 12; k++) w[12*k +: 12] = tb_out[k];
    return w;
  endfunction

  function automatic logic [143:0] fill(input logic [11:0] v);
    logic [143:0] w;
    for (int k = 0; k < 12; k++) w[12*k +: 12] = v;
    return w;
  endfunction

  function automatic logic [143:0] ramp();
    logic [143:0] w;
    for (int k = 0; k < 12; k++) w[12*k +: 12] = 12'(k);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_lane(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock of stimulus; the model predicts the registered output and the
  // prediction is popped and compared just after the edge.
  task automatic cycle(input logic en, input logic we, input logic [8:0] a,
                       input logic [143:0] wd, input string tag);
    @(negedge clock);
    ram_enable   = en;
    write_enable = we;
    address      = a;
    for (int k = 0; k < 12; k++) tb_in[k] = wd[12*k +: 12];
    if (en) m_out = m_mem[a];
    if (we) m_mem[a] = wd;
    exp_q.push_back(m_out);
    @(posedge clock);
    #1;
    chk(tag, obs_word(), exp_q.pop_front());
  endtask

  initial begin
    logic [143:0] rnd;
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
    m_out        = '0;
    reset        = 1'b1;
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    for (int k = 0; k < 12; k++) tb_in[k] = '0;

    #2;
    chk("reset_state", obs_word(), 144'd0);
    @(negedge clock);
    reset = 1'b0;

    // Untouched words read as zero.
    cycle(1'b1, 1'b0, 9'd10,  '0, "init_addr10");
    chk("init_addr10_const", obs_word(), 144'd0);
    cycle(1'b1, 1'b0, 9'd511, '0, "init_addr511");

    // Lane packing: write 0..11 then read back.
    cycle(1'b0, 1'b1, 9'd0, ramp(), "write_ramp");
    cycle(1'b1, 1'b0, 9'd0, '0, "read_ramp");
    chk_lane("ramp_lane0",  tb_out[0],  12'd0);
    chk_lane("ramp_lane5",  tb_out[5],  12'd5);
    chk_lane("ramp_lane11", tb_out[11], 12'd11);

    // Write without read enable leaves outputs alone.
    cycle(1'b0, 1'b1, 9'd1, fill(12'hABC), "wr_gate_hold");
    chk_lane("wr_gate_lane11", tb_out[11], 12'd11);
    cycle(1'b1, 1'b0, 9'd1, '0, "read_abc");
    chk("read_abc_const", obs_word(), fill(12'hABC));

    // Read-first on a simultaneous read/write.
    cycle(1'b0, 1'b1, 9'd2, fill(12'h005), "write_5s");
    cycle(1'b1, 1'b1, 9'd2, fill(12'h007), "rf_old");
    chk("rf_old_const", obs_word(), fill(12'h005));
    cycle(1'b1, 1'b0, 9'd2, '0, "rf_new");
    chk("rf_new_const", obs_word(), fill(12'h007));

    // Hold for 5 idle cycles while the address wanders.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 9'(i * 97 + 3), '0, "hold");
      chk("hold_const", obs_word(), fill(12'h007));
    end

    // Asynchronous reset mid-cycle, held across an edge with a read pending.
    #3;
    reset = 1'b1;
    #1;
    chk("reset_async", obs_word(), 144'd0);
    m_out = '0;
    @(negedge clock);
    ram_enable = 1'b1;
    address    = 9'd2;
    @(posedge clock);
    #1;
    chk("reset_held", obs_word(), 144'd0);
    @(negedge clock);
    reset      = 1'b0;
    ram_enable = 1'b0;

    // Memory survives reset.
    cycle(1'b1, 1'b0, 9'd2, '0, "post_reset_read");
    chk("post_reset_const", obs_word(), fill(12'h007));

    // Random words at the top of the array and mid-array.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 12; k++) rnd[12*k +: 12] = 12'($urandom);
      cycle(1'b0, 1'b1, (i[0] ? 9'd511 : 9'd300), rnd, "rnd_write");
      cycle(1'b1, 1'b0, (i[0] ? 9'd511 : 9'd300), '0, "rnd_read");
      chk("rnd_const", obs_word(), rnd);
    end
    cycle(1'b1, 1'b0, 9'd0, '0, "reread_ramp");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
